// File: rtl/ibundle_queue_if.sv
// ibundle_queue_if: fetch -> queue -> decode handshake bundle.
//   slave  : the queue side (consumes in_*, out_ready; drives fetch_stall, out_*)
//   master : the environment side (fetch + decode)
// Parameters: PC_W bundle address width.
interface ibundle_queue_if #(parameter int PC_W = 14);
  logic            in_valid;
  logic [127:0]    in_inst;
  logic [PC_W-1:0] in_pc;
  logic            fetch_stall;
  logic            out_valid;
  logic [31:0]     out_slot0, out_slot1, out_slot2, out_slot3;
  logic [PC_W-1:0] out_pc;
  logic            out_ready;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output fetch_stall, out_valid, out_slot0, out_slot1, out_slot2, out_slot3, out_pc
  );
  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  fetch_stall, out_valid, out_slot0, out_slot1, out_slot2, out_slot3, out_pc
  );
endinterface

// File: rtl/ibundle_queue.sv
// ibundle_queue: decoupling FIFO between instruction fetch and decode.
// Holds 128-bit VLIW bundles with their PC; head is presented to decode as
// four 32-bit slots (slot0 = bits [127:96] issues first).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         drop every entry (including a same-cycle push)
//   bus (slave)   in_valid/in_inst/in_pc from fetch, fetch_stall back to fetch,
//                 out_valid/out_slot0..3/out_pc/out_ready toward decode
//   count         occupancy, overflow sticky dropped-push flag
// Optional feature macro IBQ_PERF_CNT_EN: adds perf_stall_cycles, a saturating
// count of cycles with fetch_stall high (cleared by rst only).
module ibundle_queue #(
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 1,
  parameter int PC_W     = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  ibundle_queue_if.slave         bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
`ifdef IBQ_PERF_CNT_EN
  ,
  output logic [31:0]            perf_stall_cycles
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [127:0]    inst;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;
  logic [CW:0]     free;

  // Head is read straight out of the array: no bypass, so a push becomes
  // visible the cycle after it is written.
  assign head          = mem[rd_ptr];
  assign bus.out_pc    = head.pc;
  assign bus.out_slot0 = head.inst[127:96];
  assign bus.out_slot1 = head.inst[95:64];
  assign bus.out_slot2 = head.inst[63:32];
  assign bus.out_slot3 = head.inst[31:0];
  assign bus.out_valid = (count != '0);

  assign pop  = bus.out_valid & bus.out_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign push = bus.in_valid & ((count < CW'(DEPTH)) | pop);

  // Stall threshold leaves room for the bundle already in the fetch BRAM.
  assign free            = (CW+1)'(DEPTH) - {1'b0, count};
  assign bus.fetch_stall = (free <= (CW+1)'(AFULL_TH));

  always_ff @(posedge clk) begin
    if (push & ~flush) mem[wr_ptr] <= '{inst: bus.in_inst, pc: bus.in_pc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count  <= count + CW'(push) - CW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      if (bus.in_valid & ~push) overflow <= 1'b1;
    end
  end

`ifdef IBQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      perf_stall_cycles <= '0;
    else if (bus.fetch_stall && perf_stall_cycles != 32'hFFFF_FFFF)
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ibundle_queue.sv
module tb_ibundle_queue;
  localparam int DEPTH = 4, AFULL_TH = 1, PC_W = 14;

  logic clk = 1'b0;
  logic rst, flush;
  logic [2:0] count;
  logic overflow;
`ifdef IBQ_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  ibundle_queue_if #(.PC_W(PC_W)) bus();

  ibundle_queue #(.DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .count(count), .overflow(overflow)
`ifdef IBQ_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  // Reference model: plain queue of bundles, sticky flag, stall-cycle tally.
  typedef struct {
    logic [127:0]    inst;
    logic [PC_W-1:0] pc;
  } ent_t;
  ent_t            q[$];
  logic [PC_W-1:0] popped[$];
  bit              m_ovf;
  int unsigned     m_stall;
  int              n_chk, n_fail;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_stall_now();
    return (DEPTH - q.size()) <= AFULL_TH;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".count"}, 128'(count), 128'(q.size()));
    chk({tag, ".out_valid"}, 128'(bus.out_valid), 128'(q.size() != 0));
    chk({tag, ".fetch_stall"}, 128'(bus.fetch_stall), 128'(m_stall_now()));
    chk({tag, ".overflow"}, 128'(overflow), 128'(m_ovf));
    if (q.size() != 0) begin
      chk({tag, ".out_pc"}, 128'(bus.out_pc), 128'(q[0].pc));
      chk({tag, ".slot0"}, 128'(bus.out_slot0), 128'(q[0].inst[127:96]));
      chk({tag, ".slot1"}, 128'(bus.out_slot1), 128'(q[0].inst[95:64]));
      chk({tag, ".slot2"}, 128'(bus.out_slot2), 128'(q[0].inst[63:32]));
      chk({tag, ".slot3"}, 128'(bus.out_slot3), 128'(q[0].inst[31:0]));
    end
`ifdef IBQ_PERF_CNT_EN
    chk({tag, ".perf"}, 128'(perf_stall_cycles), 128'(m_stall));
`endif
  endtask

  task automatic drive(input bit v, input logic [PC_W-1:0] pc, input bit rdy, input bit fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_inst   = {$urandom, $urandom, $urandom, $urandom};
    bus.out_ready = rdy;
    flush         = fl;
  endtask

  // Advance one clock: model follows the queue rules on the current inputs,
  // then DUT outputs are compared 1 time unit after the edge.
  task automatic tick(input string tag);
    bit   p_pop, p_push;
    ent_t e;
    if (rst) begin
      q.delete();
      m_ovf   = 0;
      m_stall = 0;
    end else begin
      if (m_stall_now()) m_stall++;
      if (flush) q.delete();
      else begin
        p_pop  = (q.size() != 0) && bus.out_ready;
        p_push = bus.in_valid && (q.size() < DEPTH || p_pop);
        if (p_pop) begin
          popped.push_back(q[0].pc);
          void'(q.pop_front());
        end
        if (p_push) begin
          e.inst = bus.in_inst;
          e.pc   = bus.in_pc;
          q.push_back(e);
        end
        if (bus.in_valid && !p_push) m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int sent, cyc;
    rst = 1'b1;
    drive(0, '0, 0, 0);
    tick("reset");
    tick("reset");
    rst = 1'b0;
    chk("reset.count", 128'(count), 128'd0);
    chk("reset.fetch_stall", 128'(bus.fetch_stall), 128'd0);
    chk("reset.out_valid", 128'(bus.out_valid), 128'd0);

    // Fill: stall must be up once three entries are held.
    for (int i = 0; i < 4; i++) begin
      drive(1, PC_W'(i), 0, 0);
      tick("fill");
      if (i == 2) chk("fill.stall_at3", 128'(bus.fetch_stall), 128'd1);
    end
    drive(0, '0, 0, 0);
    chk("fill.count", 128'(count), 128'd4);
    chk("fill.out_pc", 128'(bus.out_pc), 128'd0);
    chk("fill.overflow", 128'(overflow), 128'd0);

    // Full with simultaneous pop: accepted, count unchanged.
    drive(1, PC_W'(4), 1, 0);
    tick("fullpp");
    chk("fullpp.count", 128'(count), 128'd4);
    chk("fullpp.out_pc", 128'(bus.out_pc), 128'd1);
    chk("fullpp.overflow", 128'(overflow), 128'd0);

    // Full without pop: dropped, overflow sets.
    drive(1, PC_W'(5), 0, 0);
    tick("ovf");
    chk("ovf.count", 128'(count), 128'd4);
    chk("ovf.overflow", 128'(overflow), 128'd1);

    // Drain: 1,2,3,4 in order, then empty.
    drive(0, '0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("drain.out_pc", 128'(bus.out_pc), 128'(i));
      tick("drain");
    end
    chk("drain.empty", 128'(bus.out_valid), 128'd0);

    // Flush mid-stream with a same-cycle push.
    for (int i = 0; i < 3; i++) begin
      drive(1, PC_W'(16 + i), 0, 0);
      tick("pref");
    end
    drive(1, PC_W'(19), 0, 1);
    tick("flush");
    chk("flush.count", 128'(count), 128'd0);
    chk("flush.out_valid", 128'(bus.out_valid), 128'd0);
    chk("flush.fetch_stall", 128'(bus.fetch_stall), 128'd0);
    chk("flush.overflow_held", 128'(overflow), 128'd1);
    drive(1, PC_W'(14'h100), 0, 0);
    tick("postflush");
    drive(0, '0, 0, 0);
    chk("postflush.out_pc", 128'(bus.out_pc), 128'h100);
    chk("postflush.out_valid", 128'(bus.out_valid), 128'd1);

    // Wrap: fetch honours stall, decode ready toggles 1010...
    rst = 1'b1;
    tick("rst2");
    rst = 1'b0;
    popped.delete();
    sent = 0;
    cyc  = 0;
    while (popped.size() < 10 && cyc < 100) begin
      drive((sent < 10) && !m_stall_now(), PC_W'(sent), (cyc % 2) == 0, 0);
      if (bus.in_valid) sent++;
      tick("wrap");
      cyc++;
    end
    chk("wrap.npopped", 128'(popped.size()), 128'd10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      chk("wrap.order", 128'(popped[i]), 128'(i));
    chk("wrap.overflow", 128'(overflow), 128'd0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, PC_W'($urandom), $urandom % 2, ($urandom % 40) == 0);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
